counter_for_dynamic_lighting: RTL and testbench

- Scan-timing generator for a multiplexed (dynamically lit) 4-digit seven-segment display.
- Divides the system clock (40 MHz nominal, 25 ns period) down to a digit-step rate.
- Outputs:
  - S_CLK: 2-bit digit-select index that cycles 0,1,2,3,0,…
  - ANODE: one-hot digit-enable decode of S_CLK.
  - TICK: one-cycle step strobe.
- Sits between the system clock and the segment/digit mux driving the display pins.

---
 rtl/counter_for_dynamic_lighting_pkg.sv | 15 +
 rtl/counter_for_dynamic_lighting_prescaler_tick.sv | 29 ++
 rtl/counter_for_dynamic_lighting.sv | 63 ++++++
 tb/tb_counter_for_dynamic_lighting.sv | 91 +++++++++
 4 files changed

// File: rtl/counter_for_dynamic_lighting_pkg.sv
// rtl/counter_for_dynamic_lighting_pkg.sv - shared display constants and divider helper
package counter_for_dynamic_lighting_pkg;

    localparam int MAX_DIGITS  = 4;
    localparam int SEL_W       = 2;
    localparam int CLK_FREQ_HZ = 40_000_000;

    // Clock cycles per digit step for a wanted per-digit rate, never below 1.
    function automatic int calc_div_count(input int clk_hz, input int step_hz);
        int div;
        div = (step_hz > 0) ? (clk_hz / step_hz) : 1;
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/counter_for_dynamic_lighting_prescaler_tick.sv
// rtl/counter_for_dynamic_lighting_prescaler_tick.sv - modulo-N counter with terminal-count strobe
module counter_for_dynamic_lighting_prescaler_tick #(
    parameter int N = 40000
) (
    input  logic clk,
    input  logic rst,
    output logic tc
);

    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // tc is combinational so the owner can register its step in the same edge as the wrap.
    always_comb begin
        tc    = (cnt_q == W'(N - 1));
        cnt_d = tc ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_for_dynamic_lighting.sv
// rtl/counter_for_dynamic_lighting.sv - digit-scan index, step strobe and anode decode
module counter_for_dynamic_lighting
    import counter_for_dynamic_lighting_pkg::*;
#(
    parameter int DIV_COUNT        = 40000,
    parameter int DIGITS           = 4,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic [SEL_W-1:0]      S_CLK,
    output logic [MAX_DIGITS-1:0] ANODE,
    output logic                  TICK
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(DIGITS - 1);

    logic                  step;
    logic [SEL_W-1:0]      s_clk_q;
    logic [SEL_W-1:0]      s_clk_d;
    logic                  tick_q;
    logic                  tick_d;
    logic [MAX_DIGITS-1:0] anode_hi;

    counter_for_dynamic_lighting_prescaler_tick #(
        .N (DIV_COUNT)
    ) u_prescaler (
        .clk (CLK),
        .rst (RST),
        .tc  (step)
    );

    // '>=' rather than '==' so an unreachable out-of-range index falls back to 0.
    always_comb begin
        s_clk_d = s_clk_q;
        tick_d  = step;
        if (step) begin
            s_clk_d = (s_clk_q >= LAST_SEL) ? '0 : s_clk_q + SEL_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s_clk_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            s_clk_q <= s_clk_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        anode_hi = '0;
        if (s_clk_q <= LAST_SEL) begin
            anode_hi[s_clk_q] = 1'b1;
        end
    end

    assign S_CLK = s_clk_q;
    assign TICK  = tick_q;
    assign ANODE = ANODE_ACTIVE_LOW ? ~anode_hi : anode_hi;

endmodule

// File: tb/tb_counter_for_dynamic_lighting.sv
// tb/tb_counter_for_dynamic_lighting.sv - randomized reset stimulus against an edge-count reference model
module tb_counter_for_dynamic_lighting;

    localparam int NI = 5;
    localparam int DIV_P[NI] = '{4, 5, 1, 7, 40000};
    localparam int DIG_P[NI] = '{4, 3, 4, 2, 4};
    localparam bit LOW_P[NI] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] s_clk [NI];
    logic [3:0] anode [NI];
    logic       tick  [NI];

    int edges_since_rst [NI];
    int n_checks = 0;
    int n_fail   = 0;

    always #12.5 clk = ~clk;

    counter_for_dynamic_lighting #(.DIV_COUNT(4), .DIGITS(4), .ANODE_ACTIVE_LOW(1'b1)) u_a (
        .CLK(clk), .RST(rst), .S_CLK(s_clk[0]), .ANODE(anode[0]), .TICK(tick[0]));
    counter_for_dynamic_lighting #(.DIV_COUNT(5), .DIGITS(3), .ANODE_ACTIVE_LOW(1'b0)) u_b (
        .CLK(clk), .RST(rst), .S_CLK(s_clk[1]), .ANODE(anode[1]), .TICK(tick[1]));
    counter_for_dynamic_lighting #(.DIV_COUNT(1), .DIGITS(4), .ANODE_ACTIVE_LOW(1'b1)) u_c (
        .CLK(clk), .RST(rst), .S_CLK(s_clk[2]), .ANODE(anode[2]), .TICK(tick[2]));
    counter_for_dynamic_lighting #(.DIV_COUNT(7), .DIGITS(2), .ANODE_ACTIVE_LOW(1'b1)) u_d (
        .CLK(clk), .RST(rst), .S_CLK(s_clk[3]), .ANODE(anode[3]), .TICK(tick[3]));
    counter_for_dynamic_lighting u_e (
        .CLK(clk), .RST(rst), .S_CLK(s_clk[4]), .ANODE(anode[4]), .TICK(tick[4]));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected state follows from how many edges have passed since RST was last sampled high.
    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            int         n;
            int         idx;
            bit         exp_tick;
            logic [3:0] exp_an;
            n        = edges_since_rst[i];
            idx      = (n / DIV_P[i]) % DIG_P[i];
            exp_tick = (n > 0) && (n % DIV_P[i] == 0);
            exp_an   = LOW_P[i] ? 4'hF : 4'h0;
            exp_an[idx] = ~exp_an[idx];
            check_eq($sformatf("s_clk[%0d] n=%0d", i, n), 32'(s_clk[i]), 32'(idx));
            check_eq($sformatf("tick[%0d] n=%0d", i, n), 32'(tick[i]), 32'(exp_tick));
            check_eq($sformatf("anode[%0d] n=%0d", i, n), 32'(anode[i]), 32'(exp_an));
        end
    endtask

    task automatic cycle(input logic r);
        rst = r;
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            edges_since_rst[i] = rst ? 0 : edges_since_rst[i] + 1;
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        for (int i = 0; i < NI; i++) edges_since_rst[i] = 0;
        @(negedge clk);

        repeat (3) cycle(1'b1);
        repeat (25) cycle(1'b0);

        // Single-cycle resets landing mid-count, then random reset pulses of varying length.
        repeat (10) cycle(1'b0);
        cycle(1'b1);
        repeat (12) cycle(1'b0);
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
        end

        // Long quiet run so the default-parameter instance completes a digit step.
        cycle(1'b1);
        repeat (40100) cycle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
